cirno9_cpu: RTL and testbench

- Minimal RV32I processor with on-chip unified 64 KiB SRAM, forming the top of the cirno9 CPU.
- Single-cycle, non-pipelined: each clock fetches, decodes, executes and retires one instruction.
- No external bus.
- Program and data are preloaded into the SRAM by backdoor write before reset is released.

---
 rtl/cirno9_cpu_if.sv | 21 ++
 rtl/cirno9_cpu.sv | 269 ++++++++++++++++++++++++++
 tb/tb_cirno9_cpu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cirno9_cpu_if.sv
// Core-to-SRAM bus: one combinational fetch port and one data port
// (combinational read, byte-enabled write at the clock edge).
interface cirno9_cpu_if;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_data;
   logic [31:0] data_addr;
   logic [31:0] data_rdata;
   logic [31:0] data_wdata;
   logic [3:0]  data_be;
   logic        data_we;

   modport master (
      output fetch_addr, data_addr, data_wdata, data_be, data_we,
      input  fetch_data, data_rdata
   );

   modport slave (
      input  fetch_addr, data_addr, data_wdata, data_be, data_we,
      output fetch_data, data_rdata
   );
endinterface

// File: rtl/cirno9_cpu.sv
// cirno9: single-cycle RV32I core with a unified on-chip SRAM.
// Every cycle out of reset fetches, executes and retires one instruction.

module cirno9_regfile (
   input  logic        clk,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);
   logic [31:0] rf_r [0:31];

   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf_r[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf_r[raddr2];

   always_ff @(posedge clk) begin
      if (we && (waddr != 5'd0)) rf_r[waddr] <= wdata;
   end
endmodule

module cirno9_exu (
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [31:0] load_data,
   output logic        in_retr,
   output logic [31:0] next_pc,
   output logic        rd_we,
   output logic [31:0] rd_wdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_we
);
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] alu_b, alu_res, pc_plus4, lane;
   logic [4:0]  shamt;
   logic        take_branch, wr, st;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign imm_i    = {{20{instr[31]}}, instr[31:20]};
   assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u    = {instr[31:12], 12'b0};
   assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign pc_plus4 = pc + 32'd4;
   assign in_retr  = ~rst_n;

   assign alu_b = (opcode == OpReg) ? rs2_val : imm_i;
   assign shamt = alu_b[4:0];

   always_comb begin
      alu_res = 32'd0;
      case (funct3)
         3'b000:  alu_res = (opcode == OpReg && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001:  alu_res = rs1_val << shamt;
         3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
         3'b011:  alu_res = {31'd0, rs1_val < alu_b};
         3'b100:  alu_res = rs1_val ^ alu_b;
         3'b101:  alu_res = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110:  alu_res = rs1_val | alu_b;
         default: alu_res = rs1_val & alu_b;
      endcase
   end

   always_comb begin
      take_branch = 1'b0;
      case (funct3)
         3'b000:  take_branch = (rs1_val == rs2_val);
         3'b001:  take_branch = (rs1_val != rs2_val);
         3'b100:  take_branch = ($signed(rs1_val) < $signed(rs2_val));
         3'b101:  take_branch = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  take_branch = (rs1_val < rs2_val);
         3'b111:  take_branch = (rs1_val >= rs2_val);
         default: take_branch = 1'b0;
      endcase
   end

   assign mem_addr = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
   assign lane     = load_data >> {mem_addr[1:0], 3'b000};

   always_comb begin
      next_pc   = pc_plus4;
      wr        = 1'b0;
      st        = 1'b0;
      rd_wdata  = 32'd0;
      mem_wdata = rs2_val;
      mem_be    = 4'b0000;
      case (opcode)
         OpLui: begin
            wr       = 1'b1;
            rd_wdata = imm_u;
         end
         OpAuipc: begin
            wr       = 1'b1;
            rd_wdata = pc + imm_u;
         end
         OpJal: begin
            wr       = 1'b1;
            rd_wdata = pc_plus4;
            next_pc  = pc + imm_j;
         end
         OpJalr: begin
            wr       = 1'b1;
            rd_wdata = pc_plus4;
            next_pc  = (rs1_val + imm_i) & ~32'd1;
         end
         OpBranch: begin
            if (take_branch) next_pc = pc + imm_b;
         end
         OpLoad: begin
            wr = 1'b1;
            case (funct3)
               3'b000:  rd_wdata = {{24{lane[7]}}, lane[7:0]};
               3'b001:  rd_wdata = {{16{lane[15]}}, lane[15:0]};
               3'b100:  rd_wdata = {24'd0, lane[7:0]};
               3'b101:  rd_wdata = {16'd0, lane[15:0]};
               default: rd_wdata = load_data;
            endcase
         end
         OpStore: begin
            st = 1'b1;
            case (funct3)
               3'b000: begin
                  mem_wdata = {4{rs2_val[7:0]}};
                  mem_be    = 4'b0001 << mem_addr[1:0];
               end
               3'b001: begin
                  mem_wdata = {2{rs2_val[15:0]}};
                  mem_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
               end
               3'b010:  mem_be = 4'b1111;
               default: st = 1'b0;
            endcase
         end
         OpImm, OpReg: begin
            wr       = 1'b1;
            rd_wdata = alu_res;
         end
         // FENCE, SYSTEM and unknown opcodes fall through as NOPs
         default: ;
      endcase
   end

   // Reset aborts the instruction in flight: no architectural write
   assign rd_we  = in_retr & wr;
   assign mem_we = in_retr & st;
endmodule

module cirno9_core #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input logic          clk,
   input logic          rst_n,
   cirno9_cpu_if.master bus
);
   logic [31:0] pc_r;
   logic [31:0] instr, rs1_val, rs2_val, next_pc, rd_wdata;
   logic        rd_we, in_retr;

   assign instr          = bus.fetch_data;
   assign bus.fetch_addr = pc_r;

   cirno9_regfile u_regfile (
      .clk    (clk),
      .raddr1 (instr[19:15]),
      .raddr2 (instr[24:20]),
      .we     (rd_we),
      .waddr  (instr[11:7]),
      .wdata  (rd_wdata),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val)
   );

   cirno9_exu u_exu (
      .rst_n     (rst_n),
      .pc        (pc_r),
      .instr     (instr),
      .rs1_val   (rs1_val),
      .rs2_val   (rs2_val),
      .load_data (bus.data_rdata),
      .in_retr   (in_retr),
      .next_pc   (next_pc),
      .rd_we     (rd_we),
      .rd_wdata  (rd_wdata),
      .mem_addr  (bus.data_addr),
      .mem_wdata (bus.data_wdata),
      .mem_be    (bus.data_be),
      .mem_we    (bus.data_we)
   );

   always_ff @(posedge clk) begin
      if (!in_retr) pc_r <= RESET_PC;
      else          pc_r <= next_pc;
   end
endmodule

module cirno9_sram32 #(
   parameter int unsigned MEM_WORDS = 16384
) (
   input logic         clk,
   cirno9_cpu_if.slave bus
);
   localparam int unsigned AW = $clog2(MEM_WORDS);

   logic [31:0]   mem_r [0:MEM_WORDS-1];
   logic [AW-1:0] f_idx, d_idx;
   logic          unused_addr_bits;

   // Upper address bits alias: memory wraps every MEM_WORDS*4 bytes
   assign f_idx = bus.fetch_addr[AW+1:2];
   assign d_idx = bus.data_addr[AW+1:2];
   assign unused_addr_bits = ^{bus.fetch_addr[31:AW+2], bus.fetch_addr[1:0],
                               bus.data_addr[31:AW+2], bus.data_addr[1:0]};

   assign bus.fetch_data = mem_r[f_idx];
   assign bus.data_rdata = mem_r[d_idx];

   always_ff @(posedge clk) begin
      if (bus.data_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.data_be[b]) mem_r[d_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
         end
      end
   end
endmodule

module cirno9_cpu #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter int unsigned MEM_WORDS = 16384
) (
   input logic clk,
   input logic rst_n
);
   cirno9_cpu_if bus ();

   cirno9_core #(
      .RESET_PC (RESET_PC)
   ) u_cirno9_core (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   cirno9_sram32 #(
      .MEM_WORDS (MEM_WORDS)
   ) u_sram32 (
      .clk (clk),
      .bus (bus)
   );
endmodule

// File: tb/tb_cirno9_cpu.sv
// Directed-program bench for cirno9_cpu: backdoor-loads small RV32I programs
// and checks PC, registers and memory against hand-computed values.
module tb_cirno9_cpu;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   cirno9_cpu dut (
      .clk   (clk),
      .rst_n (rst_n)
   );

   cirno9_cpu_if mon ();
   assign mon.fetch_addr = dut.bus.fetch_addr;

   always #5 clk = ~clk;

   localparam logic [6:0] OP_LUI = 7'b0110111, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011, OP_JALR = 7'b1100111;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OP_REG};
   endfunction

   function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16384; i++) dut.u_sram32.mem_r[i] = 32'd0;
   endtask

   function automatic logic [31:0] xr(input int idx);
      return dut.u_cirno9_core.u_regfile.rf_r[idx];
   endfunction

   initial begin
      // Program 1: ALU, memory and control-flow checks
      clear_mem();
      dut.u_sram32.mem_r[0]   = enc_i(12'd1, 5'd0, 3'b000, 5'd3, OP_IMM);       // addi x3,x0,1
      dut.u_sram32.mem_r[1]   = enc_i(12'hFFF, 5'd0, 3'b000, 5'd4, OP_IMM);     // addi x4,x0,-1
      dut.u_sram32.mem_r[2]   = {20'h80000, 5'd1, OP_LUI};                      // lui x1,0x80000
      dut.u_sram32.mem_r[3]   = enc_i(12'h404, 5'd1, 3'b101, 5'd2, OP_IMM);     // srai x2,x1,4
      dut.u_sram32.mem_r[4]   = enc_i(12'h004, 5'd1, 3'b101, 5'd6, OP_IMM);     // srli x6,x1,4
      dut.u_sram32.mem_r[5]   = enc_r(7'h20, 5'd3, 5'd0, 3'b000, 5'd7);         // sub x7,x0,x3
      dut.u_sram32.mem_r[6]   = enc_r(7'h00, 5'd4, 5'd3, 3'b011, 5'd8);         // sltu x8,x3,x4
      dut.u_sram32.mem_r[7]   = enc_r(7'h00, 5'd4, 5'd3, 3'b010, 5'd9);         // slt x9,x3,x4
      dut.u_sram32.mem_r[8]   = enc_i(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM);       // addi x0,x0,5
      dut.u_sram32.mem_r[9]   = {20'h11223, 5'd10, OP_LUI};                     // lui x10
      dut.u_sram32.mem_r[10]  = enc_i(12'h344, 5'd10, 3'b000, 5'd10, OP_IMM);   // addi x10,x10,0x344
      dut.u_sram32.mem_r[11]  = {20'h80000, 5'd11, OP_LUI};                     // lui x11,0x80000
      dut.u_sram32.mem_r[12]  = enc_s(12'h100, 5'd10, 5'd11, 3'b010);           // sw x10,0x100(x11)
      dut.u_sram32.mem_r[13]  = enc_i(12'h0AA, 5'd0, 3'b000, 5'd12, OP_IMM);    // addi x12,x0,0xAA
      dut.u_sram32.mem_r[14]  = enc_s(12'h101, 5'd12, 5'd11, 3'b000);           // sb x12,0x101(x11)
      dut.u_sram32.mem_r[15]  = enc_i(12'h101, 5'd11, 3'b000, 5'd13, OP_LD);    // lb x13
      dut.u_sram32.mem_r[16]  = enc_i(12'h102, 5'd11, 3'b101, 5'd14, OP_LD);    // lhu x14
      dut.u_sram32.mem_r[17]  = enc_b(13'd8, 5'd3, 5'd4, 3'b100);               // blt x4,x3,+8
      dut.u_sram32.mem_r[18]  = enc_i(12'd7, 5'd0, 3'b000, 5'd15, OP_IMM);      // skipped
      dut.u_sram32.mem_r[19]  = enc_b(13'd8, 5'd3, 5'd4, 3'b110);               // bltu x4,x3,+8
      dut.u_sram32.mem_r[20]  = {20'h80000, 5'd5, OP_LUI};                      // lui x5,0x80000
      dut.u_sram32.mem_r[21]  = enc_i(12'h200, 5'd5, 3'b000, 5'd5, OP_IMM);     // addi x5,x5,0x200
      dut.u_sram32.mem_r[22]  = enc_i(12'd3, 5'd5, 3'b000, 5'd1, OP_JALR);      // jalr x1,3(x5)
      dut.u_sram32.mem_r[128] = enc_j(21'd0, 5'd0);                             // jal x0,0

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_retr_in_reset", {31'd0, dut.u_cirno9_core.u_exu.in_retr}, 32'd0);
      check("pc_in_reset", dut.u_cirno9_core.pc_r, 32'h8000_0000);
      rst_n = 1'b0;
      #1;
      check("in_retr_first", {31'd0, dut.u_cirno9_core.u_exu.in_retr}, 32'd1);
      check("fetch_addr_first", mon.fetch_addr, 32'h8000_0000);

      step(3);
      check("pc_after3", dut.u_cirno9_core.pc_r, 32'h8000_000C);
      check("addi_neg", xr(4), 32'hFFFF_FFFF);
      check("lui", xr(1), 32'h8000_0000);

      step(15);
      check("srai", xr(2), 32'hF800_0000);
      check("srli", xr(6), 32'h0800_0000);
      check("sub", xr(7), 32'hFFFF_FFFF);
      check("sltu", xr(8), 32'd1);
      check("slt", xr(9), 32'd0);
      check("x0_zero", xr(0), 32'd0);
      check("sw_sb_mem", dut.u_sram32.mem_r[64], 32'h1122_AA44);
      check("lb", xr(13), 32'hFFFF_FFAA);
      check("lhu", xr(14), 32'h0000_1122);
      check("blt_taken", dut.u_cirno9_core.pc_r, 32'h8000_004C);

      step(1);
      check("bltu_not_taken", dut.u_cirno9_core.pc_r, 32'h8000_0050);
      step(3);
      check("jalr_pc", dut.u_cirno9_core.pc_r, 32'h8000_0202);
      check("jalr_link", xr(1), 32'h8000_005C);
      step(2);
      check("loop_pc", dut.u_cirno9_core.pc_r, 32'h8000_0202);

      // Mid-run reset: x3 poisoned so a leaked write of addi x3,x0,1 shows up
      dut.u_cirno9_core.u_regfile.rf_r[3] = 32'h55;
      rst_n = 1'b1;
      step(1);
      check("rst_pc", dut.u_cirno9_core.pc_r, 32'h8000_0000);
      check("rst_in_retr", {31'd0, dut.u_cirno9_core.u_exu.in_retr}, 32'd0);
      step(1);
      check("rst_no_write", xr(3), 32'h55);
      check("rst_rf_kept", xr(10), 32'h1122_3344);
      check("rst_mem_kept", dut.u_sram32.mem_r[64], 32'h1122_AA44);
      rst_n = 1'b0;
      step(1);
      check("post_rst_x3", xr(3), 32'd1);
      check("post_rst_pc", dut.u_cirno9_core.pc_r, 32'h8000_0004);

      // Program 2: pass convention, loop at tohost
      rst_n = 1'b1;
      clear_mem();
      dut.u_sram32.mem_r[0]  = enc_i(12'd1, 5'd0, 3'b000, 5'd28, OP_IMM);      // addi x28,x0,1
      dut.u_sram32.mem_r[1]  = enc_j(21'h38, 5'd0);                            // jal x0,+0x38
      dut.u_sram32.mem_r[15] = enc_j(21'd0, 5'd0);                             // jal x0,0
      dut.u_cirno9_core.u_regfile.rf_r[28] = 32'd0;
      step(2);
      rst_n = 1'b0;
      step(1);
      check("pass_x28", xr(28), 32'd1);
      check("pass_pc1", dut.u_cirno9_core.pc_r, 32'h8000_0004);
      step(1);
      check("tohost_pc", dut.u_cirno9_core.pc_r, 32'h8000_003C);
      step(5);
      check("tohost_hold", dut.u_cirno9_core.pc_r, 32'h8000_003C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
